// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler
//   Holds AES-CTR stream job descriptors from the host and runs them one at a
//   time on an aes_top instance, acting as a softreg master towards it. For
//   each job it programs the key, addresses and credits, starts the job by
//   writing the word count, then polls until no output words remain.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   softreg_req_*          host register requests (address decoded on [6:0])
//   softreg_resp_*         host read response, one cycle after the request
//   aes_req_*              registered request stream to aes_top
//   aes_resp_*             aes_top read response (output words remaining)
//
// Host map
//   writes: 0x00-0x18 key words, 0x20 src, 0x28 dst, 0x30 push {words},
//           0x38 clear jobs_done/overflow
//   reads : 0x40 jobs_done, 0x48 {occupancy[10:8], overflow[1], busy[0]}
module aes_job_scheduler #(
    parameter int LOG_DEPTH  = 2,
    parameter int ID_CREDITS = 8,
    parameter int OM_CREDITS = 8,
    parameter int POLL_GAP   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        softreg_req_valid,
    input  logic        softreg_req_isWrite,
    input  logic [31:0] softreg_req_addr,
    input  logic [63:0] softreg_req_data,
    output logic        softreg_resp_valid,
    output logic [63:0] softreg_resp_data,
    output logic        aes_req_valid,
    output logic        aes_req_isWrite,
    output logic [31:0] aes_req_addr,
    output logic [63:0] aes_req_data,
    input  logic        aes_resp_valid,
    input  logic [63:0] aes_resp_data
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int GW    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef struct packed {
        logic [255:0] key;
        logic [63:0]  src;
        logic [63:0]  dst;
        logic [33:0]  words;
    } job_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
    } aes_wr_t;

    typedef enum logic [2:0] {IDLE, LOAD, PROG, GAP, POLL_REQ, POLL_WAIT, DONE} state_t;

    // Nine-step programming sequence; the word count goes last because
    // writing it is what starts the job inside aes_top.
    function automatic aes_wr_t prog_word(input job_t j, input logic [3:0] s);
        aes_wr_t w;
        w = '0;
        case (s)
            4'd0: w = '{32'h00, j.key[63:0]};
            4'd1: w = '{32'h08, j.key[127:64]};
            4'd2: w = '{32'h10, j.key[191:128]};
            4'd3: w = '{32'h18, j.key[255:192]};
            4'd4: w = '{32'h20, j.src};
            4'd5: w = '{32'h28, j.dst};
            4'd6: w = '{32'h38, 64'(ID_CREDITS)};
            4'd7: w = '{32'h40, 64'(OM_CREDITS)};
            4'd8: w = '{32'h30, 64'(j.words)};
            default: w = '0;
        endcase
        return w;
    endfunction

    job_t                 fifo [DEPTH];
    logic [LOG_DEPTH-1:0] head, tail;
    logic [LOG_DEPTH:0]   count;
    logic [255:0]         stg_key;
    logic [63:0]          stg_src, stg_dst;
    logic [31:0]          jobs_done;
    logic                 overflow;

    state_t               state;
    job_t                 job;
    logic [3:0]           step;
    logic [GW-1:0]        gap_cnt;

    logic [6:0] addr;
    logic       host_wr, host_rd, push_req, push, pop, clear, full, busy;
    job_t       head_job;

    assign addr     = softreg_req_addr[6:0];
    assign host_wr  = softreg_req_valid &  softreg_req_isWrite;
    assign host_rd  = softreg_req_valid & ~softreg_req_isWrite;
    // Depth is a power of two, so the count MSB alone marks a full queue.
    assign full     = count[LOG_DEPTH];
    assign push_req = host_wr && (addr == 7'h30);
    // Fullness is judged before any same-cycle pop: a push into a full queue is lost.
    assign push     = push_req && !full;
    assign pop      = (state == LOAD);
    assign clear    = host_wr && (addr == 7'h38);
    assign busy     = (state != IDLE);
    assign head_job = fifo[head];

    wire unused_bits = ^{softreg_req_addr[31:7], aes_resp_data[63:34]};

    // Descriptor storage: contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push)
            fifo[tail] <= {stg_key, stg_src, stg_dst, softreg_req_data[33:0]};
    end

    // Host side: staging registers, queue pointers, counters, read responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_key            <= '0;
            stg_src            <= '0;
            stg_dst            <= '0;
            head               <= '0;
            tail               <= '0;
            count              <= '0;
            jobs_done          <= '0;
            overflow           <= 1'b0;
            softreg_resp_valid <= 1'b0;
            softreg_resp_data  <= '0;
        end else begin
            if (host_wr) begin
                case (addr)
                    7'h00: stg_key[63:0]    <= softreg_req_data;
                    7'h08: stg_key[127:64]  <= softreg_req_data;
                    7'h10: stg_key[191:128] <= softreg_req_data;
                    7'h18: stg_key[255:192] <= softreg_req_data;
                    7'h20: stg_src          <= softreg_req_data;
                    7'h28: stg_dst          <= softreg_req_data;
                    default: ;
                endcase
            end
            if (push)
                tail <= tail + LOG_DEPTH'(1);
            if (pop)
                head <= head + LOG_DEPTH'(1);
            case ({push, pop})
                2'b10:   count <= count + (LOG_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_DEPTH+1)'(1);
                default: ;
            endcase
            if (push_req && full)
                overflow <= 1'b1;
            // A host clear beats a completion landing in the same cycle.
            if (clear) begin
                jobs_done <= '0;
                overflow  <= 1'b0;
            end else if (state == DONE) begin
                jobs_done <= jobs_done + 32'd1;
            end
            softreg_resp_valid <= host_rd;
            softreg_resp_data  <= '0;
            if (host_rd) begin
                case (addr)
                    7'h40:   softreg_resp_data <= {32'b0, jobs_done};
                    7'h48:   softreg_resp_data <= {53'b0, 3'(count), 6'b0, overflow, busy};
                    default: ;
                endcase
            end
        end
    end

    // Job sequencer. aes_req_* are set on the transition into the cycle in
    // which they are presented, so the bus stays registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            job             <= '0;
            step            <= '0;
            gap_cnt         <= '0;
            aes_req_valid   <= 1'b0;
            aes_req_isWrite <= 1'b0;
            aes_req_addr    <= '0;
            aes_req_data    <= '0;
        end else begin
            aes_req_valid   <= 1'b0;
            aes_req_isWrite <= 1'b0;
            aes_req_addr    <= '0;
            aes_req_data    <= '0;
            case (state)
                IDLE: if (count != '0) state <= LOAD;
                LOAD: begin
                    job <= head_job;
                    if (head_job.words == '0) begin
                        state <= DONE;
                    end else begin
                        state           <= PROG;
                        step            <= '0;
                        aes_req_valid   <= 1'b1;
                        aes_req_isWrite <= 1'b1;
                        {aes_req_addr, aes_req_data} <= prog_word(head_job, 4'd0);
                    end
                end
                PROG: begin
                    if (step == 4'd8) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end else begin
                        step            <= step + 4'd1;
                        aes_req_valid   <= 1'b1;
                        aes_req_isWrite <= 1'b1;
                        {aes_req_addr, aes_req_data} <= prog_word(job, step + 4'd1);
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(POLL_GAP - 1)) begin
                        state         <= POLL_REQ;
                        aes_req_valid <= 1'b1;
                        aes_req_addr  <= 32'h30;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                POLL_REQ: state <= POLL_WAIT;
                POLL_WAIT: begin
                    if (aes_resp_valid) begin
                        if (aes_resp_data[33:0] == '0) begin
                            state <= DONE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                // Chain straight into the next job so queued work starts
                // the cycle after completion.
                DONE: state <= (count != '0) ? LOAD : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_job_scheduler.sv
module tb_aes_job_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        softreg_req_valid = 1'b0;
    logic        softreg_req_isWrite = 1'b0;
    logic [31:0] softreg_req_addr = '0;
    logic [63:0] softreg_req_data = '0;
    logic        softreg_resp_valid;
    logic [63:0] softreg_resp_data;
    logic        aes_req_valid;
    logic        aes_req_isWrite;
    logic [31:0] aes_req_addr;
    logic [63:0] aes_req_data;
    logic        aes_resp_valid = 1'b0;
    logic [63:0] aes_resp_data = '0;

    always #5 clk = ~clk;

    aes_job_scheduler #(.LOG_DEPTH(2), .ID_CREDITS(8), .OM_CREDITS(8), .POLL_GAP(16)) dut (
        .clk(clk), .rst(rst),
        .softreg_req_valid(softreg_req_valid), .softreg_req_isWrite(softreg_req_isWrite),
        .softreg_req_addr(softreg_req_addr), .softreg_req_data(softreg_req_data),
        .softreg_resp_valid(softreg_resp_valid), .softreg_resp_data(softreg_resp_data),
        .aes_req_valid(aes_req_valid), .aes_req_isWrite(aes_req_isWrite),
        .aes_req_addr(aes_req_addr), .aes_req_data(aes_req_data),
        .aes_resp_valid(aes_resp_valid), .aes_resp_data(aes_resp_data)
    );

    typedef struct { logic [31:0] addr; logic [63:0] data; int cyc; } exp_t;

    exp_t        sb[$];
    logic [63:0] poll_q[$];
    int          poll_cyc[$];
    int          wr_cyc[$];
    logic [63:0] stall_val = '0;
    bit          resp_pending = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // aes_top stand-in: checks every request against the scoreboard and
    // answers polls two cycles after the request, while the DUT waits.
    always @(negedge clk) begin
        exp_t e;
        if (aes_resp_valid) begin
            aes_resp_valid = 1'b0;
            aes_resp_data  = '0;
        end
        if (resp_pending) begin
            aes_resp_valid = 1'b1;
            if (poll_q.size() != 0) aes_resp_data = poll_q.pop_front();
            else aes_resp_data = stall_val;
            resp_pending = 1'b0;
        end
        if (aes_req_valid && aes_req_isWrite) begin
            wr_cyc.push_back(cyc);
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL aes_write_unexpected: got addr %h data %h at cyc %0d, expected no write",
                         aes_req_addr, aes_req_data, cyc);
            end else begin
                e = sb.pop_front();
                if (aes_req_addr !== e.addr || aes_req_data !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
                    n_fail++;
                    $display("FAIL aes_write: got addr %h data %h cyc %0d, expected addr %h data %h cyc %0d",
                             aes_req_addr, aes_req_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end else if (aes_req_valid) begin
            poll_cyc.push_back(cyc);
            n_cmp++;
            if (aes_req_addr !== 32'h30 || aes_req_data !== 64'h0) begin
                n_fail++;
                $display("FAIL aes_poll: got addr %h data %h, expected addr 30 data 0", aes_req_addr, aes_req_data);
            end
            resp_pending = 1'b1;
        end else begin
            n_cmp++;
            if (aes_req_isWrite !== 1'b0 || aes_req_addr !== 32'h0 || aes_req_data !== 64'h0) begin
                n_fail++;
                $display("FAIL aes_idle_bus: got wr %b addr %h data %h, expected all 0",
                         aes_req_isWrite, aes_req_addr, aes_req_data);
            end
        end
    end

    task automatic wr(input logic [6:0] a, input logic [63:0] d);
        @(negedge clk);
        softreg_req_valid = 1'b1; softreg_req_isWrite = 1'b1;
        softreg_req_addr = {25'b0, a}; softreg_req_data = d;
    endtask

    task automatic idle();
        @(negedge clk);
        softreg_req_valid = 1'b0; softreg_req_isWrite = 1'b0;
        softreg_req_addr = '0; softreg_req_data = '0;
    endtask

    task automatic rd(input logic [6:0] a, output logic rv, output logic [63:0] d);
        @(negedge clk);
        softreg_req_valid = 1'b1; softreg_req_isWrite = 1'b0;
        softreg_req_addr = {25'b0, a}; softreg_req_data = '0;
        @(negedge clk);
        softreg_req_valid = 1'b0; softreg_req_addr = '0;
        rv = softreg_resp_valid; d = softreg_resp_data;
    endtask

    // Expected aes_top programming for one job; t < 0 means timing unchecked.
    task automatic sb_add(input logic [255:0] key, input logic [63:0] src, input logic [63:0] dst,
                          input logic [33:0] words, input int t);
        logic [31:0] ad [9];
        logic [63:0] dv [9];
        ad = '{32'h00, 32'h08, 32'h10, 32'h18, 32'h20, 32'h28, 32'h38, 32'h40, 32'h30};
        dv = '{key[63:0], key[127:64], key[191:128], key[255:192], src, dst, 64'd8, 64'd8, {30'b0, words}};
        for (int i = 0; i < 9; i++) sb.push_back('{ad[i], dv[i], (t < 0) ? -1 : t + 2 + i});
    endtask

    task automatic push_job(input logic [255:0] key, input logic [63:0] src, input logic [63:0] dst,
                            input logic [33:0] words, input bit accept, input bit timed, output int t);
        wr(7'h00, key[63:0]);   wr(7'h08, key[127:64]);
        wr(7'h10, key[191:128]); wr(7'h18, key[255:192]);
        wr(7'h20, src); wr(7'h28, dst);
        wr(7'h30, {30'b0, words});
        t = cyc + 1;
        if (accept && words != '0) sb_add(key, src, dst, words, timed ? t : -1);
        idle();
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        logic rv; logic [63:0] d;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            rd(7'h48, rv, d);
            if (rv && d[0] == 1'b0 && d[10:8] == 3'd0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_poll(input int n, output bit ok);
        for (int i = 0; i < 200 && poll_cyc.size() < n; i++) @(negedge clk);
        ok = (poll_cyc.size() >= n);
    endtask

    task automatic test_reset();
        logic rv; logic [63:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (aes_req_valid !== 1'b0 || aes_req_addr !== 32'h0 || aes_req_data !== 64'h0 ||
            softreg_resp_valid !== 1'b0 || softreg_resp_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got aes_v %b addr %h data %h resp_v %b, expected all 0",
                     aes_req_valid, aes_req_addr, aes_req_data, softreg_resp_valid);
        end
        rst = 1'b0;
        rd(7'h48, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL reset_status: got v%b %h, expected v1 0", rv, d); end
        rd(7'h40, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL reset_jobs_done: got v%b %h, expected v1 0", rv, d); end
    endtask

    task automatic test_single_job();
        logic rv; logic [63:0] d; int t; bit ok;
        poll_cyc.delete(); wr_cyc.delete(); stall_val = '0;
        poll_q = '{64'd4, 64'd2, 64'd0};
        push_job({64'd4, 64'd3, 64'd2, 64'd1}, 64'h1000, 64'h9000, 34'd4, 1'b1, 1'b1, t);
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got busy, expected idle"); end
        n_cmp++;
        if (poll_cyc.size() != 3 || poll_cyc[0] != t + 27 || poll_cyc[1] != t + 45) begin
            n_fail++;
            $display("FAIL single_polls: got %0d polls first %0d second %0d, expected 3 at %0d %0d",
                     poll_cyc.size(), (poll_cyc.size() > 0) ? poll_cyc[0] : -1,
                     (poll_cyc.size() > 1) ? poll_cyc[1] : -1, t + 27, t + 45);
        end
        n_cmp++; if (wr_cyc.size() != 9 || sb.size() != 0) begin n_fail++; $display("FAIL single_writes: got %0d writes %0d left, expected 9 0", wr_cyc.size(), sb.size()); end
        rd(7'h40, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'd1) begin n_fail++; $display("FAIL single_jobs_done: got %h, expected 1", d); end
        rd(7'h48, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL single_status: got %h, expected 0", d); end
        rd(7'h00, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL write_only_read: got %h, expected 0", d); end
        rd(7'h50, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL unmapped_read: got %h, expected 0", d); end
    endtask

    task automatic test_zero_words();
        int t;
        wr(7'h38, '0); idle();
        poll_cyc.delete(); wr_cyc.delete();
        push_job({4{64'hDEAD}}, 64'h1, 64'h2, 34'd0, 1'b1, 1'b0, t);
        while (cyc < t + 2) @(negedge clk);
        softreg_req_valid = 1'b1; softreg_req_isWrite = 1'b0; softreg_req_addr = 32'h40;
        @(negedge clk);
        n_cmp++; if (softreg_resp_valid !== 1'b1 || softreg_resp_data !== 64'd0) begin n_fail++; $display("FAIL zero_words_early: got %h, expected 0", softreg_resp_data); end
        @(negedge clk);
        n_cmp++; if (softreg_resp_valid !== 1'b1 || softreg_resp_data !== 64'd1) begin n_fail++; $display("FAIL zero_words_done: got %h, expected 1", softreg_resp_data); end
        softreg_req_valid = 1'b0; softreg_req_addr = '0;
        repeat (5) @(negedge clk);
        n_cmp++; if (poll_cyc.size() != 0 || wr_cyc.size() != 0) begin n_fail++; $display("FAIL zero_words_bus: got %0d polls %0d writes, expected 0 0", poll_cyc.size(), wr_cyc.size()); end
    endtask

    task automatic test_overflow();
        logic rv; logic [63:0] d; int t; bit ok;
        wr(7'h38, '0); idle();
        poll_cyc.delete(); poll_q.delete(); stall_val = 64'd1;
        push_job({4{64'hA}}, 64'hA000, 64'hB000, 34'd2, 1'b1, 1'b0, t);
        wait_poll(1, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL overflow_stall: got no poll, expected poll"); end
        for (int j = 0; j < 5; j++)
            push_job({4{64'(j + 16)}}, 64'(j * 256), 64'(j * 512 + 7), 34'(j + 1), j < 4, 1'b0, t);
        rd(7'h48, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h403) begin n_fail++; $display("FAIL overflow_status: got %h, expected 403", d); end
        stall_val = '0;
        wait_idle(300, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL overflow_timeout: got busy, expected idle"); end
        rd(7'h40, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'd5) begin n_fail++; $display("FAIL overflow_jobs_done: got %h, expected 5", d); end
        rd(7'h48, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h2) begin n_fail++; $display("FAIL overflow_sticky: got %h, expected 2", d); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL overflow_sb: got %0d left, expected 0", sb.size()); end
        wr(7'h38, '0); idle();
        rd(7'h48, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL overflow_clear: got %h, expected 0", d); end
    endtask

    task automatic test_push_during_poll();
        logic rv; logic [63:0] d; int t; bit ok;
        wr(7'h38, '0); idle();
        poll_cyc.delete(); wr_cyc.delete();
        poll_q = '{64'd7, 64'd0, 64'd0};
        push_job({4{64'hC}}, 64'hC000, 64'hD000, 34'd2, 1'b1, 1'b0, t);
        wait_poll(1, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL pdp_poll: got no poll, expected poll"); end
        push_job({4{64'hE}}, 64'hE000, 64'hF000, 34'd1, 1'b1, 1'b0, t);
        rd(7'h48, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h101) begin n_fail++; $display("FAIL pdp_status: got v%b %h, expected v1 101", rv, d); end
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL pdp_timeout: got busy, expected idle"); end
        n_cmp++;
        if (wr_cyc.size() != 18 || poll_cyc.size() < 2 || wr_cyc[9] != poll_cyc[1] + 4) begin
            n_fail++;
            $display("FAIL pdp_chain: got %0d writes, B start %0d, expected 18 at %0d",
                     wr_cyc.size(), (wr_cyc.size() > 9) ? wr_cyc[9] : -1,
                     (poll_cyc.size() > 1) ? poll_cyc[1] + 4 : -1);
        end
        rd(7'h40, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'd2) begin n_fail++; $display("FAIL pdp_jobs_done: got %h, expected 2", d); end
    endtask

    task automatic test_reset_mid_prog();
        logic rv; logic [63:0] d; int t; bit ok;
        push_job({4{64'h5}}, 64'h5000, 64'h6000, 34'd6, 1'b1, 1'b1, t);
        while (cyc < t + 7) @(negedge clk);
        n_cmp++; if (aes_req_valid !== 1'b1 || aes_req_addr !== 32'h28) begin n_fail++; $display("FAIL rst_prog_step5: got v%b addr %h, expected v1 28", aes_req_valid, aes_req_addr); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (aes_req_valid !== 1'b0 || aes_req_addr !== 32'h0) begin n_fail++; $display("FAIL rst_prog_bus: got v%b addr %h, expected v0 0", aes_req_valid, aes_req_addr); end
        sb.delete(); poll_q.delete();
        rst = 1'b0;
        rd(7'h48, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL rst_prog_status: got %h, expected 0", d); end
        // Staging was cleared by reset, so a bare push carries zero key/addresses.
        wr(7'h30, 64'd3);
        t = cyc + 1;
        sb_add('0, '0, '0, 34'd3, t);
        poll_q = '{64'd0};
        idle();
        wait_idle(200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_prog_timeout: got busy, expected idle"); end
        rd(7'h40, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'd1) begin n_fail++; $display("FAIL rst_prog_jobs_done: got %h, expected 1", d); end
    endtask

    task automatic test_clear_vs_done();
        logic rv; logic [63:0] d; int t;
        push_job({4{64'h9}}, 64'h0, 64'h0, 34'd0, 1'b1, 1'b0, t);
        while (cyc < t + 2) @(negedge clk);
        softreg_req_valid = 1'b1; softreg_req_isWrite = 1'b1; softreg_req_addr = 32'h38;
        idle();
        rd(7'h40, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'd0) begin n_fail++; $display("FAIL clear_vs_done: got %h, expected 0", d); end
        rd(7'h48, rv, d);
        n_cmp++; if (rv !== 1'b1 || d !== 64'h0) begin n_fail++; $display("FAIL clear_vs_done_status: got %h, expected 0", d); end
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        test_reset();
        test_single_job();
        test_zero_words();
        test_overflow();
        test_push_during_poll();
        test_reset_mid_prog();
        test_clear_vs_done();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
